// File: rtl/dragon_loader.sv
// Byte-stream program loader: parses sync/address/count/word frames and writes 36-bit words to program RAM.
// Optional trailing XOR checksum byte is enabled by defining DRAGON_LOADER_CHECKSUM_EN.
module dragon_loader (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        RamWriteEnable,
    output logic [9:0]  RamAddress,
    output logic [35:0] RamWriteData,
    output logic        CoreHold,
    output logic        Done,
    output logic        Error
);

`ifdef DRAGON_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, WORD, WRITE, CHECK, DONE
    } state_t;
    localparam state_t FINISH = CHECK;
`else
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, WORD, WRITE, DONE
    } state_t;
    localparam state_t FINISH = DONE;
`endif

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [27:0] word_q, word_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [35:0] ram_data_q, ram_data_d;
    logic        hold_q, hold_d;
    logic        error_q, error_d;
    logic        accept;
`ifdef DRAGON_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    always_comb begin
        RxReady = 1'b0;
        case (state_q)
            IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, WORD: RxReady = ResetN;
`ifdef DRAGON_LOADER_CHECKSUM_EN
            CHECK: RxReady = ResetN;
`endif
            default: RxReady = 1'b0;
        endcase
    end

    assign accept         = RxValid && RxReady;
    assign RamWriteEnable = (state_q == WRITE);
    assign RamAddress     = ram_addr_q;
    assign RamWriteData   = ram_data_q;
    assign CoreHold       = hold_q;
    assign Done           = (state_q == DONE);
    assign Error          = error_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        hold_d     = hold_q;
        error_d    = error_q;
`ifdef DRAGON_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        if (accept && state_q inside {ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, WORD})
            csum_d = csum_q ^ RxData;
`endif
        case (state_q)
            IDLE: begin
                if (accept && RxData == 8'hA5) begin
                    state_d = ADDR_HI;
                    hold_d  = 1'b1;
                    error_d = 1'b0;
`ifdef DRAGON_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            ADDR_HI: if (accept) begin
                addr_d[9:8] = RxData[1:0];
                state_d     = ADDR_LO;
            end
            ADDR_LO: if (accept) begin
                addr_d[7:0] = RxData;
                state_d     = CNT_HI;
            end
            CNT_HI: if (accept) begin
                count_d[15:8] = RxData;
                state_d       = CNT_LO;
            end
            CNT_LO: if (accept) begin
                count_d    = {count_q[15:8], RxData};
                byte_idx_d = 3'd0;
                if ({count_q[15:8], RxData} == 16'd0) begin
                    state_d = FINISH;
                    if (FINISH == DONE)
                        hold_d = 1'b0;
                end else begin
                    state_d = WORD;
                end
            end
            WORD: if (accept) begin
                if (byte_idx_q == 3'd0) begin
                    // A corrupt leading byte aborts the frame but keeps the core stalled.
                    if (RxData[7:4] != 4'h0) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        word_d     = {24'd0, RxData[3:0]};
                        byte_idx_d = 3'd1;
                    end
                end else if (byte_idx_q == 3'd4) begin
                    ram_addr_d = addr_q;
                    ram_data_d = {word_q, RxData};
                    state_d    = WRITE;
                end else begin
                    word_d     = {word_q[19:0], RxData};
                    byte_idx_d = byte_idx_q + 3'd1;
                end
            end
            WRITE: begin
                addr_d     = addr_q + 10'd1;
                count_d    = count_q - 16'd1;
                byte_idx_d = 3'd0;
                if (count_q == 16'd1) begin
                    state_d = FINISH;
                    if (FINISH == DONE)
                        hold_d = 1'b0;
                end else begin
                    state_d = WORD;
                end
            end
`ifdef DRAGON_LOADER_CHECKSUM_EN
            CHECK: if (accept) begin
                if (RxData == csum_q) begin
                    state_d = DONE;
                    hold_d  = 1'b0;
                end else begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q    <= IDLE;
            addr_q     <= 10'd0;
            count_q    <= 16'd0;
            byte_idx_q <= 3'd0;
            word_q     <= 28'd0;
            ram_addr_q <= 10'd0;
            ram_data_q <= 36'd0;
            hold_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef DRAGON_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            hold_q     <= hold_d;
            error_q    <= error_d;
`ifdef DRAGON_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_dragon_loader.sv
// Self-checking bench for dragon_loader: frame-level model predicts RAM writes, Done pulses and flags.
module tb_dragon_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [35:0] ram_data;
    logic        core_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    bit gap_en = 1'b1;
    logic [45:0] exp_q[$];
    logic [45:0] wr_log[$];
    logic [35:0] words[16];

    dragon_loader dut (
        .Clock(clk), .ResetN(rst_n), .RxData(rx_data), .RxValid(rx_valid),
        .RxReady(rx_ready), .RamWriteEnable(ram_we), .RamAddress(ram_addr),
        .RamWriteData(ram_data), .CoreHold(core_hold), .Done(done), .Error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Per-cycle compare against the expected write stream and Done-cycle output rules.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            logic [45:0] e;
            wr_log.push_back({ram_addr, ram_data});
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h", ram_addr, ram_data);
            end else begin
                e = exp_q.pop_front();
                if (e !== {ram_addr, ram_data}) begin
                    errors++;
                    $display("FAIL write got=%0h/%0h expected=%0h/%0h", ram_addr, ram_data, e[45:36], e[35:0]);
                end
            end
            chk("write_ready_hold", {rx_ready, core_hold}, 2'b01);
        end
        if (done === 1'b1) begin
            done_seen++;
            chk("done_outputs", {core_hold, rx_ready, ram_we}, 3'b000);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        if (gap_en && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 1'b0, 1'b1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [9:0] a, input int cnt, input int bad_word,
                              input logic [7:0] bad_b0, input bit bad_csum, input int junk);
        logic [7:0] cs, b, hi;
        logic [9:0] wa;
        logic [35:0] w;
        int r, d0;
        bit err_exp;
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
        end
        send_byte(8'hA5);
        chk("sync_clears_error", error, 1'b0);
        chk("sync_sets_hold", core_hold, 1'b1);
        r  = $urandom_range(0, 63);
        hi = {r[5:0], a[9:8]};
        cs = hi ^ a[7:0] ^ cnt[15:8] ^ cnt[7:0];
        send_byte(hi);
        send_byte(a[7:0]);
        send_byte(cnt[15:8]);
        send_byte(cnt[7:0]);
        d0 = done_seen;
        err_exp = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            if (i == bad_word) begin
                send_byte(bad_b0);
                err_exp = 1'b1;
                break;
            end
            w  = words[i];
            wa = a + 10'(i);
            exp_q.push_back({wa, w});
            cs = cs ^ {4'h0, w[35:32]} ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send_byte({4'h0, w[35:32]});
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
`ifdef DRAGON_LOADER_CHECKSUM_EN
        if (!err_exp) begin
            send_byte(bad_csum ? (cs ^ 8'h5A) : cs);
            if (bad_csum) err_exp = 1'b1;
        end
`endif
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("writes_pending", exp_q.size(), 0);
        chk("done_count", done_seen - d0, err_exp ? 0 : 1);
        chk("error_flag", error, err_exp);
        chk("core_hold_end", core_hold, err_exp);
        chk("idle_ready", rx_ready, 1'b1);
        exp_q.delete();
    endtask

    task automatic chk_log(input int back, input logic [9:0] a, input logic [35:0] d);
        if (wr_log.size() > back) begin
            chk("lit_addr", wr_log[wr_log.size() - 1 - back][45:36], a);
            chk("lit_data", wr_log[wr_log.size() - 1 - back][35:0], d);
        end else begin
            chk("lit_log_size", wr_log.size(), back + 1);
        end
    endtask

    task automatic fill_words();
        for (int i = 0; i < 16; i++) words[i] = {4'($urandom), 32'($urandom)};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, ram_we, 1'b0);
        chk({tag, "_addr"}, ram_addr, 10'd0);
        chk({tag, "_data"}, ram_data, 36'd0);
        chk({tag, "_hold"}, core_hold, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_ready"}, rx_ready, 1'b0);
    endtask

    initial begin
        logic [7:0] bb;
        int cnt, bw, r1, r2;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        words[0] = 36'hF12345678;
        send_frame(10'h010, 1, -1, 8'h00, 1'b0, 0);
        chk_log(0, 10'h010, 36'hF12345678);

        fill_words();
        send_frame(10'h3FF, 2, -1, 8'h00, 1'b0, 0);
        chk_log(1, 10'h3FF, words[0]);
        chk_log(0, 10'h000, words[1]);

        // Leading junk (00 FF) before sync must be discarded.
        fill_words();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(10'h123, 2, -1, 8'h00, 1'b0, 0);

        send_frame(10'h200, 0, -1, 8'h00, 1'b0, 0);

        fill_words();
        send_frame(10'h055, 3, 0, 8'h1F, 1'b0, 0);
        fill_words();
        send_frame(10'h056, 2, -1, 8'h00, 1'b0, 1);

`ifdef DRAGON_LOADER_CHECKSUM_EN
        fill_words();
        send_frame(10'h0AA, 2, -1, 8'h00, 1'b1, 0);
        chk_log(0, 10'h0AB, words[1]);
`endif

        gap_en = 1'b0;
        fill_words();
        words[1][31:24] = 8'hA5;
        send_frame(10'h300, 3, -1, 8'h00, 1'b0, 0);

        // Reset right after the first word's write.
        fill_words();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h03);
        exp_q.push_back({10'h040, words[0]});
        send_byte({4'h0, words[0][35:32]});
        send_byte(words[0][31:24]);
        send_byte(words[0][23:16]);
        send_byte(words[0][15:8]);
        send_byte(words[0][7:0]);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        chk("midreset_write_seen", exp_q.size(), 0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gap_en = 1'b1;

        for (int k = 0; k < 12; k++) begin
            fill_words();
            cnt = $urandom_range(0, 4);
            bw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            r1  = $urandom_range(1, 15);
            r2  = $urandom_range(0, 15);
            bb  = {r1[3:0], r2[3:0]};
            gap_en = ($urandom_range(0, 1) == 1);
            send_frame(10'($urandom), cnt, bw, bb, ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
